stable_vector_synchronizer: RTL and testbench

Brings an asynchronous multi-bit vector (static configuration straps, slow status buses, switch banks) into a single clock domain without a source clock or handshake. Each bit passes through a STAGES-deep flop chain. The synchronized vector is committed to the output only after it has held one identical value for STABLE_CYCLES consecutive cycles, so bit skew and short glitches never produce intermediate output codes. It succeeds the closed-loop vector synchronizer for sources that have no clock or cannot wait on a busy signal. It adds a configurable stability filter, a reset value and an update strobe.

---
 rtl/stable_vector_synchronizer.sv | 122 ++++++++++++
 tb/tb_stable_vector_synchronizer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stable_vector_synchronizer.sv
// stable_vector_synchronizer
// Brings an asynchronous multi-bit vector into the clock domain through a
// per-bit flop chain. The synchronized value reaches data_out only after it
// has held one identical value for STABLE_CYCLES consecutive samples, so bit
// skew and short glitches never produce intermediate output codes.
module stable_vector_synchronizer #(
   parameter int               WIDTH         = 8,
   parameter int               STAGES        = 2,
   parameter int               STABLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             update,
   output logic             busy
);

   localparam int             CNT_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam bit             SINGLE     = (STABLE_CYCLES == 1);

   typedef enum logic {
      IDLE,
      SETTLING
   } state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [STAGES-1:0][WIDTH-1:0] sync_chain;
   logic [WIDTH-1:0]             s;
   logic [WIDTH-1:0]             cand;
   logic [WIDTH-1:0]             cand_nxt;
   logic [CNT_W-1:0]             cnt;
   logic [CNT_W-1:0]             cnt_nxt;
   logic [WIDTH-1:0]             out_nxt;
   logic                         update_nxt;

   // Plain flop chain per bit; nothing between stages so each bit gets the
   // full resolution time of every stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_chain <= {STAGES{RESET_VALUE}};
      end else begin
         sync_chain <= {sync_chain[STAGES-2:0], data_in};
      end
   end

   assign s = sync_chain[STAGES-1];

   // State register of the stability filter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stability filter: track a candidate and commit it once it has been seen
   // STABLE_CYCLES times in a row; any other value restarts the window, and
   // a return to the committed value abandons the candidate silently.
   always_comb begin
      state_nxt  = state;
      cand_nxt   = cand;
      cnt_nxt    = cnt;
      out_nxt    = data_out;
      update_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (s != data_out) begin
               if (SINGLE) begin
                  out_nxt    = s;
                  update_nxt = 1'b1;
               end else begin
                  cand_nxt  = s;
                  cnt_nxt   = CNT_ONE;
                  state_nxt = SETTLING;
               end
            end
         end
         SETTLING: begin
            if (s == data_out) begin
               state_nxt = IDLE;
            end else if (s != cand) begin
               cand_nxt = s;
               cnt_nxt  = CNT_ONE;
            end else if (cnt == CNT_LAST) begin
               out_nxt    = cand;
               update_nxt = 1'b1;
               state_nxt  = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Candidate, counter and registered outputs; reset discards any
   // in-flight candidate.
   always_ff @(posedge clock) begin
      if (reset) begin
         cand     <= RESET_VALUE;
         cnt      <= '0;
         data_out <= RESET_VALUE;
         update   <= 1'b0;
      end else begin
         cand     <= cand_nxt;
         cnt      <= cnt_nxt;
         data_out <= out_nxt;
         update   <= update_nxt;
      end
   end

   assign busy = (state == SETTLING);

endmodule

// File: tb/tb_stable_vector_synchronizer.sv
// Bench for stable_vector_synchronizer: default instance (STAGES=2,
// STABLE_CYCLES=4) plus a STAGES=3, STABLE_CYCLES=1 instance. Expected commits
// are queued when stimulus is applied and popped when update is seen.
module tb_stable_vector_synchronizer;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       update;
   logic       busy;
   logic [7:0] data_in2;
   logic [7:0] data_out2;
   logic       update2;
   logic       busy2;

   typedef struct {
      logic [7:0] value;
      int         edge_no;
   } commit_t;

   commit_t sb[$];
   int      n_checks = 0;
   int      n_fail   = 0;

   always #5 clock = ~clock;

   stable_vector_synchronizer #(
      .WIDTH(8), .STAGES(2), .STABLE_CYCLES(4), .RESET_VALUE(8'h00)
   ) dut (
      .clock(clock), .reset(reset), .data_in(data_in),
      .data_out(data_out), .update(update), .busy(busy)
   );

   stable_vector_synchronizer #(
      .WIDTH(8), .STAGES(3), .STABLE_CYCLES(1), .RESET_VALUE(8'h00)
   ) dut2 (
      .clock(clock), .reset(reset), .data_in(data_in2),
      .data_out(data_out2), .update(update2), .busy(busy2)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      data_in  = 8'h00;
      data_in2 = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      tick();
      sb.delete();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      data_in  = 8'hA5;
      data_in2 = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_out: got %h expected 00", data_out);
         end
         n_checks++;
         if (update !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_update: got %b expected 0", update);
         end
         n_checks++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
         end
      end
      reset   = 1'b0;
      data_in = 8'h00;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (data_out !== 8'h00 || update !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: data_out=%h update=%b expected 00/0", data_out, update);
         end
      end
   endtask

   task automatic test_single_change();
      commit_t exp;
      do_reset();
      data_in = 8'h3C;
      sb.push_back('{8'h3C, 6});
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (update === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL single_extra_update: edge %0d data_out=%h expected no update", e, data_out);
            end else begin
               exp = sb.pop_front();
               n_checks++;
               if (data_out !== exp.value || e != exp.edge_no) begin
                  n_fail++;
                  $display("FAIL single_commit: data_out=%h at edge %0d expected %h at edge %0d", data_out, e, exp.value, exp.edge_no);
               end
            end
         end
         if (e < 6) begin
            n_checks++;
            if (data_out !== 8'h00) begin
               n_fail++;
               $display("FAIL single_early: edge %0d data_out=%h expected 00", e, data_out);
            end
         end
         n_checks++;
         if (busy !== (e >= 3 && e <= 5)) begin
            n_fail++;
            $display("FAIL single_busy: edge %0d busy=%b expected %b", e, busy, (e >= 3 && e <= 5));
         end
      end
      n_checks++;
      if (sb.size() != 0 || data_out !== 8'h3C) begin
         n_fail++;
         $display("FAIL single_missing: pending=%0d data_out=%h expected 0 pending, 3c", sb.size(), data_out);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      data_in = 8'hFF;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 2) data_in = 8'h00;
         n_checks++;
         if (update !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL glitch_out: edge %0d data_out=%h update=%b expected 00/0", e, data_out, update);
         end
         n_checks++;
         if (busy !== (e == 3 || e == 4)) begin
            n_fail++;
            $display("FAIL glitch_busy: edge %0d busy=%b expected %b", e, busy, (e == 3 || e == 4));
         end
      end
   endtask

   task automatic test_skew();
      commit_t exp;
      do_reset();
      data_in = 8'h03;
      tick();
      data_in = 8'h0F;
      sb.push_back('{8'h0F, 7});
      for (int e = 2; e <= 11; e++) begin
         tick();
         if (update === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL skew_extra_update: edge %0d data_out=%h expected no update", e, data_out);
            end else begin
               exp = sb.pop_front();
               n_checks++;
               if (data_out !== exp.value || e != exp.edge_no) begin
                  n_fail++;
                  $display("FAIL skew_commit: data_out=%h at edge %0d expected %h at edge %0d", data_out, e, exp.value, exp.edge_no);
               end
            end
         end
         n_checks++;
         if (data_out === 8'h03) begin
            n_fail++;
            $display("FAIL skew_intermediate: edge %0d data_out=%h expected never 03", e, data_out);
         end
         n_checks++;
         if (busy !== (e >= 3 && e <= 6)) begin
            n_fail++;
            $display("FAIL skew_busy: edge %0d busy=%b expected %b", e, busy, (e >= 3 && e <= 6));
         end
      end
      n_checks++;
      if (sb.size() != 0 || data_out !== 8'h0F) begin
         n_fail++;
         $display("FAIL skew_missing: pending=%0d data_out=%h expected 0 pending, 0f", sb.size(), data_out);
      end
   endtask

   task automatic test_reset_mid_settling();
      commit_t exp;
      do_reset();
      data_in = 8'h55;
      for (int e = 1; e <= 4; e++) begin
         tick();
         n_checks++;
         if (busy !== (e >= 3) || update !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pre: edge %0d busy=%b update=%b expected %b/0", e, busy, update, (e >= 3));
         end
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (data_out !== 8'h00 || busy !== 1'b0 || update !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_during: data_out=%h busy=%b update=%b expected 00/0/0", data_out, busy, update);
      end
      reset = 1'b0;
      sb.push_back('{8'h55, 11});
      for (int e = 6; e <= 14; e++) begin
         tick();
         if (update === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL midrst_extra_update: edge %0d data_out=%h expected no update", e, data_out);
            end else begin
               exp = sb.pop_front();
               n_checks++;
               if (data_out !== exp.value || e != exp.edge_no) begin
                  n_fail++;
                  $display("FAIL midrst_commit: data_out=%h at edge %0d expected %h at edge %0d", data_out, e, exp.value, exp.edge_no);
               end
            end
         end
         n_checks++;
         if (busy !== (e >= 8 && e <= 10)) begin
            n_fail++;
            $display("FAIL midrst_busy: edge %0d busy=%b expected %b", e, busy, (e >= 8 && e <= 10));
         end
      end
      n_checks++;
      if (sb.size() != 0 || data_out !== 8'h55) begin
         n_fail++;
         $display("FAIL midrst_missing: pending=%0d data_out=%h expected 0 pending, 55", sb.size(), data_out);
      end
   endtask

   task automatic test_back_to_back();
      commit_t exp;
      do_reset();
      data_in = 8'h11;
      sb.push_back('{8'h11, 6});
      sb.push_back('{8'h22, 10});
      for (int e = 1; e <= 13; e++) begin
         tick();
         if (e == 4) data_in = 8'h22;
         if (update === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_extra_update: edge %0d data_out=%h expected no update", e, data_out);
            end else begin
               exp = sb.pop_front();
               n_checks++;
               if (data_out !== exp.value || e != exp.edge_no) begin
                  n_fail++;
                  $display("FAIL b2b_commit: data_out=%h at edge %0d expected %h at edge %0d", data_out, e, exp.value, exp.edge_no);
               end
            end
         end
         n_checks++;
         if (busy !== ((e >= 3 && e <= 5) || (e >= 7 && e <= 9))) begin
            n_fail++;
            $display("FAIL b2b_busy: edge %0d busy=%b expected %b", e, busy, ((e >= 3 && e <= 5) || (e >= 7 && e <= 9)));
         end
      end
      n_checks++;
      if (sb.size() != 0 || data_out !== 8'h22) begin
         n_fail++;
         $display("FAIL b2b_missing: pending=%0d data_out=%h expected 0 pending, 22", sb.size(), data_out);
      end
   endtask

   task automatic test_param_sweep();
      commit_t exp;
      do_reset();
      data_in2 = 8'h81;
      sb.push_back('{8'h81, 4});
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (update2 === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sweep_extra_update: edge %0d data_out=%h expected no update", e, data_out2);
            end else begin
               exp = sb.pop_front();
               n_checks++;
               if (data_out2 !== exp.value || e != exp.edge_no) begin
                  n_fail++;
                  $display("FAIL sweep_commit: data_out=%h at edge %0d expected %h at edge %0d", data_out2, e, exp.value, exp.edge_no);
               end
            end
         end
         if (e < 4) begin
            n_checks++;
            if (data_out2 !== 8'h00) begin
               n_fail++;
               $display("FAIL sweep_early: edge %0d data_out=%h expected 00", e, data_out2);
            end
         end
         n_checks++;
         if (busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_busy: edge %0d busy=%b expected 0", e, busy2);
         end
      end
      n_checks++;
      if (sb.size() != 0 || data_out2 !== 8'h81) begin
         n_fail++;
         $display("FAIL sweep_missing: pending=%0d data_out=%h expected 0 pending, 81", sb.size(), data_out2);
      end
   endtask

   initial begin
      reset    = 1'b1;
      data_in  = 8'h00;
      data_in2 = 8'h00;
      test_reset();
      test_single_change();
      test_glitch();
      test_skew();
      test_reset_mid_settling();
      test_back_to_back();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
